config_loader: RTL and testbench



---
 rtl/config_loader_pkg.sv | 36 +++
 rtl/pe_id_decoder.sv | 34 +++
 rtl/config_loader.sv | 132 +++++++++++++
 tb/tb_config_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/config_loader_pkg.sv
// ============================================================================
//  Module      : config_loader_pkg
//  Description : Shared types for the PE-array configuration loader.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package config_loader_pkg;

    localparam int C_PE_ID_BIT_LENGTH           = 4;
    localparam int C_NEIGHBOR_PE_NUM_BIT_LENGTH = 3;
    localparam int C_OPERATION_BIT_LENGTH       = 4;
    localparam int C_DATA_WIDTH                 = 32;
    localparam int C_CONTEXT_SIZE_BIT_LENGTH    = 3;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_START = 2'd2,
        ST_RUN   = 2'd3
    } loader_state_t;

    // PE ConfigData fields plus the routing/framing fields of the input stream
    typedef struct packed {
        logic [C_PE_ID_BIT_LENGTH-1:0]           pe_id;
        logic [C_CONTEXT_SIZE_BIT_LENGTH-1:0]    index;
        logic [C_NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] input_PE_1;
        logic [C_NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] input_PE_2;
        logic [C_OPERATION_BIT_LENGTH-1:0]       op;
        logic [C_DATA_WIDTH-1:0]                 const_data;
        logic                                    last;
    } ConfigWord;

endpackage

`default_nettype wire

// File: rtl/pe_id_decoder.sv
// ============================================================================
//  Module      : pe_id_decoder
//  Description : Binary PE id to one-hot strobe with PE/context range check.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module pe_id_decoder #(
    parameter int PE_NUM                  = 16,
    parameter int PE_ID_BIT_LENGTH        = 4,
    parameter int CONTEXT_SIZE_BIT_LENGTH = 3,
    parameter int CONTEXT_SW_SIZE         = 4
) (
    input  logic [PE_ID_BIT_LENGTH-1:0]        pe_id,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] index,
    output logic [PE_NUM-1:0]                  onehot,
    output logic                               legal
);

    logic [31:0] w_pe_id_ext;
    logic [31:0] w_index_ext;

    assign w_pe_id_ext = {{(32-PE_ID_BIT_LENGTH){1'b0}}, pe_id};
    assign w_index_ext = {{(32-CONTEXT_SIZE_BIT_LENGTH){1'b0}}, index};
    assign legal       = (w_pe_id_ext < PE_NUM) && (w_index_ext < CONTEXT_SW_SIZE);

    // An illegal word must never raise any strobe
    for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_onehot
        assign onehot[gi] = legal && (w_pe_id_ext == gi);
    end

endmodule

`default_nettype wire

// File: rtl/config_loader.sv
// ============================================================================
//  Module      : config_loader
//  Description : Streams config words onto the PE config bus, then pulses
//                config_reset and reports the array as running.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module config_loader
    import config_loader_pkg::*;
#(
    parameter int PE_NUM                     = 16,
    parameter int PE_ID_BIT_LENGTH           = 4,
    parameter int NEIGHBOR_PE_NUM_BIT_LENGTH = 3,
    parameter int OPERATION_BIT_LENGTH       = 4,
    parameter int DATA_WIDTH                 = 32,
    parameter int CONTEXT_SIZE_BIT_LENGTH    = 3,
    parameter int CONTEXT_SW_SIZE            = 4,
    parameter int WORD_COUNT_WIDTH           = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [PE_ID_BIT_LENGTH-1:0]           cfg_pe_id,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    cfg_index,
    input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] cfg_input_PE_1,
    input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] cfg_input_PE_2,
    input  logic [OPERATION_BIT_LENGTH-1:0]       cfg_op,
    input  logic [DATA_WIDTH-1:0]                 cfg_const_data,
    input  logic                                  cfg_last,
    input  logic                                  reload,
    output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_1,
    output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_2,
    output logic [OPERATION_BIT_LENGTH-1:0]       config_op,
    output logic [DATA_WIDTH-1:0]                 config_const_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    config_index,
    output logic [PE_NUM-1:0]                     write_config_data,
    output logic                                  config_reset,
    output logic                                  run_active,
    output logic                                  cfg_error,
    output logic [WORD_COUNT_WIDTH-1:0]           word_count
);

    localparam logic [WORD_COUNT_WIDTH-1:0] c_count_one = {{(WORD_COUNT_WIDTH-1){1'b0}}, 1'b1};

    loader_state_t     r_state;
    logic [PE_NUM-1:0] w_onehot;
    logic              w_legal;
    logic              w_xfer;

    pe_id_decoder #(
        .PE_NUM                  (PE_NUM),
        .PE_ID_BIT_LENGTH        (PE_ID_BIT_LENGTH),
        .CONTEXT_SIZE_BIT_LENGTH (CONTEXT_SIZE_BIT_LENGTH),
        .CONTEXT_SW_SIZE         (CONTEXT_SW_SIZE)
    ) u_pe_id_decoder (
        .pe_id  (cfg_pe_id),
        .index  (cfg_index),
        .onehot (w_onehot),
        .legal  (w_legal)
    );

    // cfg_ready is registered and high only in LOAD, so it qualifies the transfer
    assign w_xfer = cfg_valid && cfg_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= ST_LOAD;
            cfg_ready         <= 1'b1;
            config_input_PE_1 <= '0;
            config_input_PE_2 <= '0;
            config_op         <= '0;
            config_const_data <= '0;
            config_index      <= '0;
            write_config_data <= '0;
            config_reset      <= 1'b0;
            run_active        <= 1'b0;
            cfg_error         <= 1'b0;
            word_count        <= '0;
        end else begin
            write_config_data <= '0;
            config_reset      <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_xfer) begin
                        if (word_count != {WORD_COUNT_WIDTH{1'b1}}) begin
                            word_count <= word_count + c_count_one;
                        end
                        if (w_legal) begin
                            config_input_PE_1 <= cfg_input_PE_1;
                            config_input_PE_2 <= cfg_input_PE_2;
                            config_op         <= cfg_op;
                            config_const_data <= cfg_const_data;
                            config_index      <= cfg_index;
                            write_config_data <= w_onehot;
                        end else begin
                            cfg_error <= 1'b1;
                        end
                        if (cfg_last) begin
                            r_state   <= ST_FLUSH;
                            cfg_ready <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state      <= ST_START;
                    config_reset <= 1'b1;
                end
                ST_START: begin
                    r_state    <= ST_RUN;
                    run_active <= 1'b1;
                end
                ST_RUN: begin
                    if (reload) begin
                        r_state    <= ST_LOAD;
                        cfg_ready  <= 1'b1;
                        run_active <= 1'b0;
                        word_count <= '0;
                        cfg_error  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_config_loader.sv
// ============================================================================
//  Module      : tb_config_loader
//  Description : Directed self-checking bench for config_loader.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_config_loader;

    localparam int PE_NUM = 12;
    localparam int WCW    = 4;

    logic        clk;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_pe_id;
    logic [2:0]  cfg_index;
    logic [2:0]  cfg_input_PE_1;
    logic [2:0]  cfg_input_PE_2;
    logic [3:0]  cfg_op;
    logic [31:0] cfg_const_data;
    logic        cfg_last;
    logic        reload;
    logic [2:0]  config_input_PE_1;
    logic [2:0]  config_input_PE_2;
    logic [3:0]  config_op;
    logic [31:0] config_const_data;
    logic [2:0]  config_index;
    logic [PE_NUM-1:0] write_config_data;
    logic        config_reset;
    logic        run_active;
    logic        cfg_error;
    logic [WCW-1:0] word_count;

    int n_tests;
    int n_fail;

    config_loader #(
        .PE_NUM           (PE_NUM),
        .CONTEXT_SW_SIZE  (4),
        .WORD_COUNT_WIDTH (WCW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_pe_id         (cfg_pe_id),
        .cfg_index         (cfg_index),
        .cfg_input_PE_1    (cfg_input_PE_1),
        .cfg_input_PE_2    (cfg_input_PE_2),
        .cfg_op            (cfg_op),
        .cfg_const_data    (cfg_const_data),
        .cfg_last          (cfg_last),
        .reload            (reload),
        .config_input_PE_1 (config_input_PE_1),
        .config_input_PE_2 (config_input_PE_2),
        .config_op         (config_op),
        .config_const_data (config_const_data),
        .config_index      (config_index),
        .write_config_data (write_config_data),
        .config_reset      (config_reset),
        .run_active        (run_active),
        .cfg_error         (cfg_error),
        .word_count        (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs set before the call are sampled at that edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [3:0] pe, input logic [2:0] idx, input logic [3:0] op,
                        input logic [31:0] cst, input logic last);
        cfg_valid      = 1'b1;
        cfg_pe_id      = pe;
        cfg_index      = idx;
        cfg_op         = op;
        cfg_const_data = cst;
        cfg_last       = last;
    endtask

    task automatic do_reload();
        cfg_valid = 1'b0;
        reload    = 1'b1;
        step();
        reload    = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1; cfg_valid = 1'b0; reload = 1'b0; cfg_last = 1'b0;
        cfg_pe_id = '0; cfg_index = '0; cfg_input_PE_1 = '0; cfg_input_PE_2 = '0;
        cfg_op = '0; cfg_const_data = '0;
        step(); step();
        chk("rst_ready", cfg_ready, 1);
        chk("rst_strobe", write_config_data, 0);
        chk("rst_cfgrst", config_reset, 0);
        chk("rst_run", run_active, 0);
        chk("rst_err", cfg_error, 0);
        chk("rst_count", word_count, 0);
        chk("rst_const", config_const_data, 0);
        chk("rst_op", config_op, 0);
        reset = 1'b0;
        step();

        // four back-to-back legal words, last on the fourth
        for (int i = 0; i < 4; i++) begin
            word(4'(i), 3'd0, 4'd1, 32'(i + 10), i == 3);
            step();
            chk("b2b_strobe", write_config_data, 64'(1) << i);
            chk("b2b_const", config_const_data, 64'(i + 10));
            chk("b2b_count", word_count, 64'(i + 1));
        end
        cfg_valid = 1'b0; cfg_last = 1'b0;
        chk("flush_ready", cfg_ready, 0);
        chk("flush_cfgrst", config_reset, 0);
        step();
        chk("start_cfgrst", config_reset, 1);
        chk("start_strobe", write_config_data, 0);
        chk("start_run", run_active, 0);
        step();
        chk("run_active", run_active, 1);
        chk("run_cfgrst", config_reset, 0);

        // valid in RUN does nothing
        word(4'd5, 3'd0, 4'd3, 32'h99, 1'b0);
        step(); step();
        chk("run_nostrobe", write_config_data, 0);
        chk("run_count", word_count, 4);
        chk("run_ready", cfg_ready, 0);
        chk("run_bushold", config_const_data, 13);
        do_reload();
        chk("rl_ready", cfg_ready, 1);
        chk("rl_run", run_active, 0);
        chk("rl_count", word_count, 0);

        // illegal words then a legal one
        word(4'd12, 3'd0, 4'd1, 32'h1, 1'b0);
        step();
        chk("ill_pe_strobe", write_config_data, 0);
        chk("ill_pe_err", cfg_error, 1);
        word(4'd2, 3'd4, 4'd1, 32'h2, 1'b0);
        step();
        chk("ill_idx_strobe", write_config_data, 0);
        chk("ill_idx_count", word_count, 2);
        word(4'd7, 3'd3, 4'd2, 32'h55, 1'b1);
        step();
        cfg_valid = 1'b0; cfg_last = 1'b0;
        chk("leg_strobe", write_config_data, 12'h080);
        chk("leg_index", config_index, 3);
        chk("leg_err_sticky", cfg_error, 1);
        step();
        chk("cfgrst2", config_reset, 1);
        step();
        chk("run2", run_active, 1);
        do_reload();
        chk("rl_err", cfg_error, 0);

        // valid toggling every other cycle, full field check
        cfg_input_PE_1 = 3'd3; cfg_input_PE_2 = 3'd6;
        word(4'd4, 3'd2, 4'd5, 32'hDEADBEEF, 1'b0);
        step();
        cfg_valid = 1'b0;
        chk("tog_strobe1", write_config_data, 12'h010);
        chk("tog_op", config_op, 5);
        chk("tog_const", config_const_data, 32'hDEADBEEF);
        chk("tog_in1", config_input_PE_1, 3);
        chk("tog_in2", config_input_PE_2, 6);
        chk("tog_index", config_index, 2);
        step();
        chk("tog_idle", write_config_data, 0);
        chk("tog_hold", config_const_data, 32'hDEADBEEF);
        cfg_input_PE_1 = 3'd1; cfg_input_PE_2 = 3'd0;
        word(4'd9, 3'd1, 4'd7, 32'h12345678, 1'b0);
        step();
        cfg_valid = 1'b0;
        chk("tog_strobe2", write_config_data, 12'h200);
        chk("tog_const2", config_const_data, 32'h12345678);
        step();
        chk("tog_idle2", write_config_data, 0);
        chk("tog_count", word_count, 2);

        // reset during a burst
        word(4'd0, 3'd0, 4'd1, 32'h0, 1'b0); step();
        word(4'd1, 3'd0, 4'd1, 32'h0, 1'b0); step();
        word(4'd2, 3'd0, 4'd1, 32'h0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0; cfg_valid = 1'b0;
        chk("mid_rst_strobe", write_config_data, 0);
        chk("mid_rst_count", word_count, 0);
        chk("mid_rst_ready", cfg_ready, 1);
        step();
        chk("mid_rst_nocfgrst", config_reset, 0);
        chk("mid_rst_norun", run_active, 0);

        // saturation with a 4-bit counter
        word(4'd0, 3'd0, 4'd1, 32'h0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            step();
            if (i == 14) chk("sat_15", word_count, 15);
        end
        cfg_valid = 1'b0;
        chk("sat_hold", word_count, 15);
        chk("sat_ready", cfg_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
